// File: rtl/key_event_ctrl.sv
// key_event_ctrl: PS/2 scan-code decoder feeding a fall-through event FIFO,
// with live held-key tracking for five game keys and a sticky overflow flag.
module key_event_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [4:0] held,
  output logic       ovf,
  input  logic       ovf_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(PREFIX_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic emit, pend, full, pop, wr, is_pre, is_junk;
  logic [9:0] pend_ev, head;
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [4:0] hmask;
  assign is_pre  = rx_data == 8'hE0 || rx_data == 8'hF0;
  assign is_junk = rx_data inside {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF};
  // A prefix byte never emits; in a non-idle state it either advances or aborts.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = '0;
    emit      = 1'b0;
    if (rx_valid) begin
      state_nxt = state == IDLE ? (rx_data == 8'hE0 ? EXT : rx_data == 8'hF0 ? BRK : IDLE)
                : (state == EXT && rx_data == 8'hF0) ? EXT_BRK : IDLE;
      emit      = !is_pre && !(state == IDLE && is_junk);
    end else if (state != IDLE) begin
      state_nxt = tcnt == TLAST ? IDLE : state;
      tcnt_nxt  = tcnt == TLAST ? '0 : tcnt + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tcnt    <= '0;
      pend    <= 1'b0;
      pend_ev <= '0;
    end else begin
      state   <= state_nxt;
      tcnt    <= tcnt_nxt;
      pend    <= emit;
      pend_ev <= {state == BRK || state == EXT_BRK, state == EXT || state == EXT_BRK, rx_data};
    end
  end
  assign pop       = evt_valid && evt_ready;
  assign full      = count == (AW+1)'(FIFO_DEPTH);
  assign wr        = pend && (!full || pop);
  assign head      = mem[rd_ptr];
  assign evt_valid = count != '0;
  assign evt_code  = evt_valid ? head[7:0] : '0;
  assign evt_ext   = evt_valid && head[8];
  assign evt_break = evt_valid && head[9];
  assign hmask = {!pend_ev[8] && pend_ev[7:0] == 8'h29,
                  pend_ev[8] && pend_ev[7:0] == 8'h75,
                  pend_ev[8] && pend_ev[7:0] == 8'h72,
                  pend_ev[8] && pend_ev[7:0] == 8'h74,
                  pend_ev[8] && pend_ev[7:0] == 8'h6B};
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= pend_ev;
  end
  // Held keys follow every decoded event, even ones the full FIFO drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      held   <= '0;
    end else begin
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      count  <= count + (AW+1)'(wr) - (AW+1)'(pop);
      ovf    <= (pend && full && !pop) || (ovf && !ovf_clr);
      held   <= pend ? (pend_ev[9] ? held & ~hmask : held | hmask) : held;
    end
  end
endmodule

// File: doc/key_event_ctrl.md
KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the number of event FIFO entries (power of two, 2..16).
REQ-002 Parameter PREFIX_TIMEOUT, default 100000, sets the clk cycles allowed between a prefix byte and the next byte.
REQ-003 Port clk  input  1  is the system clock; all logic is on its rising edge.
REQ-004 Port rst  input  1  is the asynchronous, active-high reset.
REQ-005 Port rx_data  input  8  carries a received PS/2 byte from the keyboard receiver.
REQ-006 Port rx_valid  input  1  is a one-cycle strobe; rx_data is valid in that same cycle.
REQ-007 Port evt_valid  output  1  is high while the FIFO is non-empty.
REQ-008 Port evt_ready  input  1  is the consumer acceptance; a pop occurs on a cycle with evt_valid && evt_ready.
REQ-009 Port evt_code  output  8  is the FIFO head scan code, with prefixes stripped.
REQ-010 Port evt_ext  output  1  is high when the head event carried the E0 prefix.
REQ-011 Port evt_break  output  1  is high for a key release and low for a key press.
REQ-012 Port held  output  5  gives live key state: [0] left E0 6B, [1] right E0 74, [2] down E0 72, [3] rotate E0 75, [4] drop 29 (non-ext).
REQ-013 Port ovf  output  1  is a sticky FIFO overflow flag.
REQ-014 Port ovf_clr  input  1  clears ovf when high on a clock edge.

Function
REQ-015 The decoder SHALL have four states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen).
REQ-016 On rx_valid, transitions SHALL be: IDLE--E0-->EXT; IDLE--F0-->BRK; EXT--F0-->EXT_BRK.
REQ-017 On rx_valid, any other byte in a state SHALL complete an event {code, ext=state∈{EXT,EXT_BRK}, break=state∈{BRK,EXT_BRK}}, and the FSM SHALL return to IDLE.
REQ-018 In IDLE, bytes 00, AA, E1, FA, FE and FF SHALL be discarded with no event and no state change.
REQ-019 E0 received in EXT, BRK or EXT_BRK, or F0 received in BRK or EXT_BRK, SHALL be a protocol error: the FSM goes to IDLE, and no event is produced for that byte.
REQ-020 In any non-IDLE state, a timeout counter SHALL count cycles without rx_valid and reset to 0 on each rx_valid.
REQ-021 When the timeout counter reaches PREFIX_TIMEOUT-1, the FSM SHALL return to IDLE and discard the prefix, with no event.
REQ-022 A completed event SHALL be written to the FIFO on the cycle after its rx_valid.
REQ-023 If the FIFO was empty, evt_valid SHALL rise in the cycle after the write edge (2-cycle latency from rx_valid).
REQ-024 The FIFO SHALL be first-word fall-through: evt_code, evt_ext and evt_break always reflect the head entry.
REQ-025 When evt_valid is low, evt_code, evt_ext and evt_break SHALL be 0.
REQ-026 A simultaneous push and pop SHALL both take effect in the same cycle, including when the FIFO is full (count unchanged) or empty-with-bypass not permitted (the pushed entry appears the next cycle).
REQ-027 A push when the FIFO is full and no pop occurs SHALL drop the new event and set ovf.
REQ-028 If set and clear occur in the same cycle, ovf SHALL end up 1 (set wins).
REQ-029 held bits SHALL update on the same edge as the FIFO write of a matching event: press sets the bit, release clears it.
REQ-030 held bits SHALL update regardless of FIFO fullness.
REQ-031 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 Occupancy SHALL be tracked with a count of width clog2(FIFO_DEPTH)+1.

Reset
REQ-033 While rst is high, all of the following SHALL hold: FSM=IDLE, timeout counter=0, FIFO empty (pointers and count 0), evt_valid=0, evt_code=0, evt_ext=0, evt_break=0, held=0, ovf=0.
REQ-034 Reset asserted in the middle of a prefix sequence SHALL discard the partial sequence; the first byte after reset is decoded from IDLE.

Verification
REQ-035 Extended press and release: bytes E0 6B, then E0 F0 6B, evt_ready=1 -> event {6B,ext=1,brk=0}, then {6B,ext=1,brk=1}; held[0] goes 1 then 0; evt_valid is asserted 2 cycles after the final byte's strobe.
REQ-036 Non-extended release: bytes 29, F0 29 -> events {29,0,0} and {29,0,1}; held[4] pulses.
REQ-037 Overflow: evt_ready=0, 5 make codes 1C 32 21 23 24 with depth 4 -> FIFO holds 1C 32 21 23; ovf=1; popping returns that order; ovf_clr clears ovf.
REQ-038 Full with simultaneous push and pop: FIFO full, evt_ready=1 on the same cycle as a push -> no ovf; count stays 4; the new code becomes the tail.
REQ-039 Timeout and filtering: E0 followed by PREFIX_TIMEOUT idle cycles, then 6B -> event {6B,ext=0}; a lone AA or FA -> no event.
REQ-040 Error and reset: E0 E0 -> FSM in IDLE with no event; F0 followed by rst pulse, then 1C -> press event {1C,0,0}.
